axi_lite_reg_tester: RTL and testbench

Parametrised AXI4-Lite master that drives a self-checking register sweep against any AXI4-Lite slave in the design, such as the convolution layer's control slave.
- On a start edge it writes `C_NUM_REGS` generated patterns to consecutive word addresses from `C_BASE_ADDR`, reads each back and compares.
- It reports done, error, error count and first failing address.
- Compared with the fixed 4-register example master, it generalises width, register count and data pattern, and adds a selectable sweep mode plus error accounting.

---
 rtl/axi_lite_reg_tester_if.sv | 51 +++++
 rtl/axi_lite_reg_tester.sv | 208 ++++++++++++++++++++
 tb/tb_axi_lite_reg_tester.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_tester_if.sv
// AXI4-Lite bundle between the register sweep master and its target slave.
interface axi_lite_reg_tester_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [2:0]      M_AXI_AWPROT;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic [2:0]      M_AXI_ARPROT;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_reg_tester.sv
// AXI4-Lite master: writes generated patterns to a register window,
// reads them back, and accounts for bad responses and mismatches.
module axi_lite_reg_tester #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_MODE = 0,
  parameter logic [31:0] C_SEED = 32'h0101FFFF,
  parameter logic [31:0] C_STEP = 32'h11111111
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          INIT_AXI_TXN,
  output logic                          TXN_DONE,
  output logic                          ERROR,
  output logic [7:0]                    ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
  axi_lite_reg_tester_if.master         m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [7:0] LAST = 8'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_init_prev, w_start, w_accept;
  logic [7:0]    r_wi, r_ri, w_wi_nxt, w_ri_nxt;
  logic          r_awvalid, r_wvalid, r_arvalid;
  logic          r_aw_done, r_w_done;
  logic [AW-1:0] r_awaddr, r_araddr, w_fail_addr;
  logic [DW-1:0] r_wdata, r_exp;
  logic          w_aw_hs, w_w_hs, w_ar_hs;
  logic          w_fail, w_wr_go, w_rd_go;

  function automatic logic [AW-1:0] addr_of(input logic [7:0] i);
    return C_BASE_ADDR + AW'(i) * AW'(DW / 8);
  endfunction

  function automatic logic [DW-1:0] pat_of(input logic [7:0] i);
    return DW'(C_SEED) + DW'(i) * DW'(C_STEP);
  endfunction

  assign w_start  = INIT_AXI_TXN & ~r_init_prev;
  assign w_accept = w_start &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_aw_hs  = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid & m_axi.M_AXI_WREADY;
  assign w_ar_hs  = r_arvalid & m_axi.M_AXI_ARREADY;

  always_comb begin
    w_state_nxt = r_state;
    w_wi_nxt    = r_wi;
    w_ri_nxt    = r_ri;
    w_wr_go     = 1'b0;
    w_rd_go     = 1'b0;
    w_fail      = 1'b0;
    w_fail_addr = r_awaddr;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_state_nxt = S_WRITE;
          w_wi_nxt    = '0;
          w_ri_nxt    = '0;
        end
      end
      S_WRITE: begin
        // first write after a start is launched one cycle into WRITE
        w_wr_go = ~r_aw_done & ~r_w_done & ~r_awvalid & ~r_wvalid;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs))
          w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        if (m_axi.M_AXI_BVALID) begin
          w_fail = (m_axi.M_AXI_BRESP != 2'b00);
          if (C_MODE == 0 || r_wi == LAST) begin
            w_state_nxt = S_READ;
            w_rd_go     = 1'b1;
          end else begin
            w_wi_nxt    = r_wi + 8'd1;
            w_state_nxt = S_WRITE;
            w_wr_go     = 1'b1;
          end
        end
      end
      S_READ: begin
        if (w_ar_hs) w_state_nxt = S_RDATA;
      end
      S_RDATA: begin
        if (m_axi.M_AXI_RVALID) begin
          w_fail = (m_axi.M_AXI_RRESP != 2'b00) |
                   (m_axi.M_AXI_RDATA != r_exp);
          w_fail_addr = r_araddr;
          if (r_ri == LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ri_nxt = r_ri + 8'd1;
            if (C_MODE == 0) begin
              w_wi_nxt    = r_wi + 8'd1;
              w_state_nxt = S_WRITE;
              w_wr_go     = 1'b1;
            end else begin
              w_state_nxt = S_READ;
              w_rd_go     = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_init_prev <= 1'b0;
      r_wi        <= '0;
      r_ri        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_prev <= INIT_AXI_TXN;
      r_wi        <= w_wi_nxt;
      r_ri        <= w_ri_nxt;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_go) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= addr_of(w_wi_nxt);
      r_wdata   <= pat_of(w_wi_nxt);
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_exp     <= '0;
    end else if (w_rd_go) begin
      r_arvalid <= 1'b1;
      r_araddr  <= addr_of(w_ri_nxt);
      r_exp     <= pat_of(w_ri_nxt);
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      TXN_DONE       <= 1'b0;
      ERROR          <= 1'b0;
      ERR_COUNT      <= '0;
      FIRST_ERR_ADDR <= '0;
    end else if (w_accept) begin
      TXN_DONE       <= 1'b0;
      ERROR          <= 1'b0;
      ERR_COUNT      <= '0;
      FIRST_ERR_ADDR <= '0;
    end else begin
      if (r_state == S_RDATA && w_state_nxt == S_DONE)
        TXN_DONE <= 1'b1;
      if (w_fail) begin
        ERROR <= 1'b1;
        if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
        if (ERR_COUNT == 8'd0) FIRST_ERR_ADDR <= w_fail_addr;
      end
    end
  end

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = (r_state == S_WRESP);
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = (r_state == S_RDATA);
endmodule

// File: tb/tb_axi_lite_reg_tester.sv
// Directed bench: two sweep masters (interleaved x4, block x8) against
// small memory slaves with error injection and backpressure knobs.
module tb_axi_lite_reg_tester;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init0, init1;
  int checks = 0;
  int failures = 0;

  axi_lite_reg_tester_if #(.AW(32), .DW(32)) m0();
  axi_lite_reg_tester_if #(.AW(32), .DW(32)) m1();

  logic        done0, err0, done1, err1;
  logic [7:0]  cnt0, cnt1;
  logic [31:0] fa0, fa1;

  axi_lite_reg_tester dut0 (
    .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init0),
    .TXN_DONE(done0), .ERROR(err0), .ERR_COUNT(cnt0),
    .FIRST_ERR_ADDR(fa0), .m_axi(m0)
  );

  axi_lite_reg_tester #(.C_NUM_REGS(8), .C_MODE(1)) dut1 (
    .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init1),
    .TXN_DONE(done1), .ERROR(err1), .ERR_COUNT(cnt1),
    .FIRST_ERR_ADDR(fa1), .m_axi(m1)
  );

  logic [31:0] EXP [8] = '{32'h0101FFFF, 32'h12131110, 32'h23242221,
                           32'h34353332, 32'h45464443, 32'h56575554,
                           32'h67686665, 32'h78797776};

  // slave 0: memory with backpressure / corruption / bad BRESP knobs
  logic [31:0] mem0 [16];
  logic bp = 1'b0, corrupt = 1'b0, berr = 1'b0;
  logic s0_aw, s0_w, s0_ar;
  logic [31:0] s0_awa, s0_wd, s0_ara;

  always @(posedge clk) begin
    if (rst) begin
      m0.M_AXI_AWREADY <= 1'b0; m0.M_AXI_WREADY <= 1'b0;
      m0.M_AXI_ARREADY <= 1'b0; m0.M_AXI_BVALID <= 1'b0;
      m0.M_AXI_BRESP <= 2'b00;  m0.M_AXI_RVALID <= 1'b0;
      m0.M_AXI_RRESP <= 2'b00;  m0.M_AXI_RDATA <= '0;
      s0_aw <= 1'b0; s0_w <= 1'b0; s0_ar <= 1'b0;
    end else begin
      m0.M_AXI_AWREADY <= bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      m0.M_AXI_WREADY  <= bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      m0.M_AXI_ARREADY <= bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (m0.M_AXI_AWVALID && m0.M_AXI_AWREADY) begin
        s0_aw <= 1'b1; s0_awa <= m0.M_AXI_AWADDR;
      end
      if (m0.M_AXI_WVALID && m0.M_AXI_WREADY) begin
        s0_w <= 1'b1; s0_wd <= m0.M_AXI_WDATA;
      end
      if (s0_aw && s0_w && !m0.M_AXI_BVALID) begin
        mem0[s0_awa[5:2]] <= s0_wd;
        m0.M_AXI_BVALID <= 1'b1;
        m0.M_AXI_BRESP <= berr ? 2'b10 : 2'b00;
        s0_aw <= 1'b0; s0_w <= 1'b0;
      end
      if (m0.M_AXI_BVALID && m0.M_AXI_BREADY) m0.M_AXI_BVALID <= 1'b0;
      if (m0.M_AXI_ARVALID && m0.M_AXI_ARREADY) begin
        s0_ar <= 1'b1; s0_ara <= m0.M_AXI_ARADDR;
      end
      if (s0_ar && !m0.M_AXI_RVALID) begin
        m0.M_AXI_RVALID <= 1'b1;
        m0.M_AXI_RRESP <= 2'b00;
        m0.M_AXI_RDATA <= mem0[s0_ara[5:2]] ^
                          ((corrupt && s0_ara == 32'd8) ? 32'd1 : 32'd0);
        s0_ar <= 1'b0;
      end
      if (m0.M_AXI_RVALID && m0.M_AXI_RREADY) m0.M_AXI_RVALID <= 1'b0;
    end
  end

  // slave 1: plain zero-wait memory
  logic [31:0] mem1 [16];
  logic s1_aw, s1_w, s1_ar;
  logic [31:0] s1_awa, s1_wd, s1_ara;

  always @(posedge clk) begin
    if (rst) begin
      m1.M_AXI_AWREADY <= 1'b0; m1.M_AXI_WREADY <= 1'b0;
      m1.M_AXI_ARREADY <= 1'b0; m1.M_AXI_BVALID <= 1'b0;
      m1.M_AXI_BRESP <= 2'b00;  m1.M_AXI_RVALID <= 1'b0;
      m1.M_AXI_RRESP <= 2'b00;  m1.M_AXI_RDATA <= '0;
      s1_aw <= 1'b0; s1_w <= 1'b0; s1_ar <= 1'b0;
    end else begin
      m1.M_AXI_AWREADY <= 1'b1;
      m1.M_AXI_WREADY  <= 1'b1;
      m1.M_AXI_ARREADY <= 1'b1;
      if (m1.M_AXI_AWVALID && m1.M_AXI_AWREADY) begin
        s1_aw <= 1'b1; s1_awa <= m1.M_AXI_AWADDR;
      end
      if (m1.M_AXI_WVALID && m1.M_AXI_WREADY) begin
        s1_w <= 1'b1; s1_wd <= m1.M_AXI_WDATA;
      end
      if (s1_aw && s1_w && !m1.M_AXI_BVALID) begin
        mem1[s1_awa[5:2]] <= s1_wd;
        m1.M_AXI_BVALID <= 1'b1;
        s1_aw <= 1'b0; s1_w <= 1'b0;
      end
      if (m1.M_AXI_BVALID && m1.M_AXI_BREADY) m1.M_AXI_BVALID <= 1'b0;
      if (m1.M_AXI_ARVALID && m1.M_AXI_ARREADY) begin
        s1_ar <= 1'b1; s1_ara <= m1.M_AXI_ARADDR;
      end
      if (s1_ar && !m1.M_AXI_RVALID) begin
        m1.M_AXI_RVALID <= 1'b1;
        m1.M_AXI_RDATA <= mem1[s1_ara[5:2]];
        s1_ar <= 1'b0;
      end
      if (m1.M_AXI_RVALID && m1.M_AXI_RREADY) m1.M_AXI_RVALID <= 1'b0;
    end
  end

  // handshake monitors, sampled on the pre-edge values
  int aw_cnt, w_cnt, ar_cnt, stab_err, aw1_cnt, ar1_cnt, order_err;
  logic [31:0] aw_log [16], w_log [16];
  logic pa = 1'b0, pw = 1'b0, pr = 1'b0;
  logic [31:0] pa_v, pw_v, pr_v;

  always @(posedge clk) begin
    if (rst) begin
      pa = 1'b0; pw = 1'b0; pr = 1'b0;
    end else begin
      if (pa && (!m0.M_AXI_AWVALID || m0.M_AXI_AWADDR !== pa_v)) stab_err++;
      if (pw && (!m0.M_AXI_WVALID || m0.M_AXI_WDATA !== pw_v)) stab_err++;
      if (pr && (!m0.M_AXI_ARVALID || m0.M_AXI_ARADDR !== pr_v)) stab_err++;
      pa = m0.M_AXI_AWVALID && !m0.M_AXI_AWREADY; pa_v = m0.M_AXI_AWADDR;
      pw = m0.M_AXI_WVALID && !m0.M_AXI_WREADY;   pw_v = m0.M_AXI_WDATA;
      pr = m0.M_AXI_ARVALID && !m0.M_AXI_ARREADY; pr_v = m0.M_AXI_ARADDR;
      if (m0.M_AXI_AWVALID && m0.M_AXI_AWREADY) begin
        if (aw_cnt < 16) aw_log[aw_cnt] = m0.M_AXI_AWADDR;
        aw_cnt++;
      end
      if (m0.M_AXI_WVALID && m0.M_AXI_WREADY) begin
        if (w_cnt < 16) w_log[w_cnt] = m0.M_AXI_WDATA;
        w_cnt++;
      end
      if (m0.M_AXI_ARVALID && m0.M_AXI_ARREADY) ar_cnt++;
      if (m1.M_AXI_AWVALID && m1.M_AXI_AWREADY) begin
        if (ar1_cnt > 0) order_err++;
        aw1_cnt++;
      end
      if (m1.M_AXI_ARVALID && m1.M_AXI_ARREADY) ar1_cnt++;
    end
  end

  task automatic clr_mon();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; stab_err = 0;
    aw1_cnt = 0; ar1_cnt = 0; order_err = 0;
  endtask

  task automatic start0();
    @(negedge clk); init0 = 1'b1;
    @(negedge clk); init0 = 1'b0;
  endtask

  task automatic wait0(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (done0) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rst_error got=%0b exp=0", err0); end
    checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d exp=0", cnt0); end
    checks++; if (fa0 !== 32'd0) begin failures++; $display("FAIL rst_firstaddr got=%h exp=0", fa0); end
    checks++; if ({m0.M_AXI_AWVALID, m0.M_AXI_WVALID, m0.M_AXI_ARVALID, m0.M_AXI_BREADY, m0.M_AXI_RREADY} !== 5'b0)
      begin failures++; $display("FAIL rst_handshake got=%b exp=00000", {m0.M_AXI_AWVALID, m0.M_AXI_WVALID, m0.M_AXI_ARVALID, m0.M_AXI_BREADY, m0.M_AXI_RREADY}); end
    checks++; if (m0.M_AXI_AWADDR !== 32'd0 || m0.M_AXI_WDATA !== 32'd0)
      begin failures++; $display("FAIL rst_bus got=%h/%h exp=0/0", m0.M_AXI_AWADDR, m0.M_AXI_WDATA); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    clr_mon();
    @(negedge clk); init0 = 1'b1;
    @(negedge clk); init0 = 1'b0;
    checks++; if (m0.M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL basic_valid_lag got=%0b exp=0", m0.M_AXI_AWVALID); end
    @(negedge clk);
    checks++; if (!(m0.M_AXI_AWVALID === 1'b1 && m0.M_AXI_WVALID === 1'b1 && m0.M_AXI_WDATA === 32'h0101FFFF))
      begin failures++; $display("FAIL basic_first_valid got=%b%b %h exp=11 0101ffff", m0.M_AXI_AWVALID, m0.M_AXI_WVALID, m0.M_AXI_WDATA); end
    wait0(cyc);
    checks++; if (cyc !== 24) begin failures++; $display("FAIL basic_latency got=%0d exp=24", cyc); end
    checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0) begin failures++; $display("FAIL basic_error got=%0b/%0d exp=0/0", err0, cnt0); end
    checks++; if (aw_cnt !== 4 || ar_cnt !== 4) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=4/4", aw_cnt, ar_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aw_log[i] !== 32'(4 * i) || w_log[i] !== EXP[i] || mem0[i] !== EXP[i])
        begin failures++; $display("FAIL basic_write%0d got=%h:%h exp=%h:%h", i, aw_log[i], w_log[i], 4 * i, EXP[i]); end
    end
  endtask

  task automatic test_mode1();
    clr_mon();
    @(negedge clk); init1 = 1'b1;
    @(negedge clk); init1 = 1'b0;
    for (int i = 0; i < 500 && done1 !== 1'b1; i++) @(negedge clk);
    checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL mode1_done got=%0b exp=1", done1); end
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL mode1_error got=%0b exp=0", err1); end
    checks++; if (aw1_cnt !== 8 || ar1_cnt !== 8) begin failures++; $display("FAIL mode1_counts got=%0d/%0d exp=8/8", aw1_cnt, ar1_cnt); end
    checks++; if (order_err !== 0) begin failures++; $display("FAIL mode1_order got=%0d exp=0", order_err); end
    checks++; if (mem1[7] !== EXP[7] || mem1[4] !== EXP[4]) begin failures++; $display("FAIL mode1_mem got=%h/%h exp=%h/%h", mem1[7], mem1[4], EXP[7], EXP[4]); end
  endtask

  task automatic test_corrupt();
    int cyc;
    corrupt = 1'b1;
    start0();
    wait0(cyc);
    corrupt = 1'b0;
    checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL corrupt_done got=%0b exp=1", done0); end
    checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL corrupt_error got=%0b exp=1", err0); end
    checks++; if (cnt0 !== 8'd1) begin failures++; $display("FAIL corrupt_count got=%0d exp=1", cnt0); end
    checks++; if (fa0 !== 32'd8) begin failures++; $display("FAIL corrupt_addr got=%h exp=8", fa0); end
  endtask

  task automatic test_bresp();
    int cyc;
    berr = 1'b1;
    start0();
    wait0(cyc);
    berr = 1'b0;
    checks++; if (cyc < 0) begin failures++; $display("FAIL bresp_done got=timeout exp=done"); end
    checks++; if (cnt0 !== 8'd4) begin failures++; $display("FAIL bresp_count got=%0d exp=4", cnt0); end
    checks++; if (fa0 !== 32'd0 || err0 !== 1'b1) begin failures++; $display("FAIL bresp_addr got=%h/%0b exp=0/1", fa0, err0); end
  endtask

  task automatic test_backpressure();
    int cyc;
    clr_mon();
    bp = 1'b1;
    start0();
    wait0(cyc);
    bp = 1'b0;
    checks++; if (cyc < 0) begin failures++; $display("FAIL bp_done got=timeout exp=done"); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    checks++; if (aw_cnt !== 4 || w_cnt !== 4 || ar_cnt !== 4)
      begin failures++; $display("FAIL bp_counts got=%0d/%0d/%0d exp=4/4/4", aw_cnt, w_cnt, ar_cnt); end
    checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0) begin failures++; $display("FAIL bp_error got=%0b/%0d exp=0/0", err0, cnt0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aw_log[i] !== 32'(4 * i) || w_log[i] !== EXP[i])
        begin failures++; $display("FAIL bp_write%0d got=%h:%h exp=%h:%h", i, aw_log[i], w_log[i], 4 * i, EXP[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    clr_mon();
    start0();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m0.M_AXI_BREADY === 1'b1 && aw_cnt == 3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_reach got=timeout exp=wresp_reg2"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({m0.M_AXI_AWVALID, m0.M_AXI_WVALID, m0.M_AXI_ARVALID, m0.M_AXI_BREADY, m0.M_AXI_RREADY} !== 5'b0)
      begin failures++; $display("FAIL rmid_valid got=%b exp=00000", {m0.M_AXI_AWVALID, m0.M_AXI_WVALID, m0.M_AXI_ARVALID, m0.M_AXI_BREADY, m0.M_AXI_RREADY}); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rmid_done got=%0b exp=0", done0); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    clr_mon();
    start0();
    wait0(cyc);
    checks++; if (cyc < 0 || err0 !== 1'b0) begin failures++; $display("FAIL rmid_restart got=%0d/%0b exp=done/0", cyc, err0); end
    checks++; if (aw_cnt !== 4 || ar_cnt !== 4) begin failures++; $display("FAIL rmid_counts got=%0d/%0d exp=4/4", aw_cnt, ar_cnt); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clr_mon();
    start0();
    repeat (8) @(negedge clk);
    init0 = 1'b1;
    @(negedge clk); init0 = 1'b0;
    wait0(cyc);
    repeat (10) @(negedge clk);
    checks++; if (aw_cnt !== 4 || w_cnt !== 4) begin failures++; $display("FAIL b2b_writes got=%0d/%0d exp=4/4", aw_cnt, w_cnt); end
    checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL b2b_done got=%0b/%0b exp=1/0", done0, err0); end
  endtask

  initial begin
    rst = 1'b1; init0 = 1'b0; init1 = 1'b0;
    clr_mon();
    test_reset();
    test_basic();
    test_mode1();
    test_corrupt();
    test_bresp();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
